function_sweeper: RTL and testbench
===================================

# function_sweeper

Sequential stimulus-and-check block for the 5-input minimized SOP function in this project. It drives the five function inputs X, Y, Z, K, M through all 32 combinations. After each combination it waits a settle time, then samples the function output returned on `f_in` and compares it against the golden truth table. It sits in front of the combinational function (as initiator to its responder) and reports pass/fail, error count and first failing index for board-level self-test.

## Interface
Parameters:
- SETTLE, default 2: cycles each vector is held before sampling; legal range 1–15.
- EXPECTED, default 32'h0AAE8D5D: golden truth table; bit i = expected f for index i = {X,Y,Z,K,M}, with X as MSB (minterms 0,2,3,4,6,8,10,11,15,17,18,19,21,23,25,27).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk, input, 1, sole clock, rising edge.
  - rst, input, 1, asynchronous active-high reset.
- Control and response inputs:
  - start, input, 1, begins a sweep; sampled only in IDLE.
  - f_in, input, 1, function output under test.
- Stimulus outputs (all registered):
  - X, Y, Z, K, M, output, 1 each, index bits 4..0.
- Status and result outputs:
  - busy, output, 1, high from DRIVE through SAMPLE of the last vector.
  - done, output, 1, one-cycle pulse at end of sweep.
  - pass, output, 1, 1 when err_count==0 after the last sweep.
  - err_count, output, 6, mismatches in the last sweep (0–32).
  - first_err_idx, output, 5, index of the first mismatch; 0 if none.
  - fail_map, output, 32, per-index mismatch bitmap (see Configuration).

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, FIN.
- Transitions:
  - IDLE→DRIVE on start=1. This clears idx, err_count, first_err_idx, pass and fail_map, and loads settle counter = SETTLE-1.
  - DRIVE: counter decrements; →SAMPLE when counter==0.
  - SAMPLE: compare f_in with EXPECTED[idx].
    - On mismatch: err_count+1. If err_count was 0, latch first_err_idx=idx.
    - Then, if idx==31, go →FIN; otherwise idx+1 and →DRIVE with the counter reloaded.
  - FIN: done=1; pass=(err_count==0); →IDLE.
- Stimulus: {X,Y,Z,K,M}=idx in DRIVE and SAMPLE; all 0 in IDLE and FIN.
- Index is 5 bits. The 31→0 wrap is never taken; the sweep ends in FIN instead.
- start is ignored outside IDLE, including in FIN.
- Results hold their values through IDLE until the next start.
- Reset:
  - Asynchronous, valid in any state, including mid-sweep.
  - Forces IDLE and sets all outputs to 0 (X..M, busy, done, pass, err_count, first_err_idx, fail_map).
  - The next start after reset runs a full clean sweep.
- err_count is 6 bits so that 32 mismatches cannot overflow.

## Timing
- Start edge at cycle 0. Vector 0 appears on X..M after that edge.
- Each vector is held SETTLE+1 cycles: SETTLE cycles in DRIVE, 1 cycle in SAMPLE. f_in is sampled at the SAMPLE closing edge.
- done pulses in the cycle starting 32·(SETTLE+1) edges after the start edge. With the default SETTLE=2 that is 96 edges.
- busy falls in the same edge on which done rises.
- pass, err_count and first_err_idx are stable from the done cycle onward.
- No combinational path from f_in or start to any output.

## Configuration
- Macro: SWEEP_FAILMAP_EN.
- Defined: fail_map bit idx is set on a mismatch in SAMPLE and held until the next start or reset.
- Undefined: the fail_map register is omitted and the port is tied to 32'h0. All other behaviour is identical.

## Structure
- Shared package function_sweep_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, FIN);
  - IDX_W=5, CNT_W=6;
  - EXPECTED_DEFAULT=32'h0AAE8D5D.
- One sub-module is natural: sweep_settle_timer, a loadable down-counter with a zero flag. The FSM, index and result registers stay in function_sweeper.

## Test plan
- f_in wired to a golden combinational model of the function, SETTLE=2, start pulse → done at edge 96, pass=1, err_count=0, first_err_idx=0, fail_map=0.
- f_in tied 0 → err_count=16, first_err_idx=0, pass=0, fail_map=32'h0AAE8D5D with SWEEP_FAILMAP_EN defined.
- f_in tied 1 → err_count=16, first_err_idx=1, pass=0, fail_map=32'hF5517 2A2 bitwise complement, i.e. 32'hF55172A2.
- Golden model with f_in inverted only at idx 19 → err_count=1, first_err_idx=19, fail_map=32'h00080000.
- Assert rst while idx=10 → all outputs 0 immediately; deassert rst, then start → full 96-cycle sweep, pass=1.
- start pulsed again at idx 5 and during FIN → ignored; done pulses exactly once and the sweep length is unchanged.

Source files
------------

// File: rtl/function_sweep_pkg.sv
// function_sweep_pkg: shared state type and sizing constants for the function sweeper.
package function_sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_e;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;
    localparam logic [31:0] EXPECTED_DEFAULT = 32'h0AAE8D5D;
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter that holds at zero and flags it.
module sweep_settle_timer
    import function_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/function_sweeper.sv
// function_sweeper: drives all 32 input vectors, checks f_in against a golden table.
// Optional per-index failure bitmap enabled with SWEEP_FAILMAP_EN.
module function_sweeper
    import function_sweep_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter logic [31:0] EXPECTED = EXPECTED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        K,
    output logic        M,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [4:0]  first_err_idx,
    output logic [31:0] fail_map
);
    state_e           state_q;
    logic [IDX_W-1:0] idx_q, stim_q, first_q;
    logic [5:0]       err_q;
    logic             busy_q, done_q, pass_q, cnt_zero, mismatch, launch;
    assign mismatch = f_in ^ EXPECTED[idx_q];
    assign launch   = state_q == IDLE && start;
    sweep_settle_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (launch || (state_q == SAMPLE && idx_q != '1)),
        .load_val_i(CNT_W'(SETTLE - 1)),
        .zero_o    (cnt_zero)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            first_q <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= DRIVE;
                    idx_q   <= '0;
                    stim_q  <= '0;
                    first_q <= '0;
                    err_q   <= '0;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                DRIVE: if (cnt_zero) state_q <= SAMPLE;
                SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_q + 6'd1;
                        if (err_q == '0) first_q <= idx_q;
                    end
                    // pass is resolved here so it already counts the last vector's result
                    if (idx_q == '1) begin
                        state_q <= FIN;
                        stim_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_q == '0 && !mismatch;
                    end else begin
                        state_q <= DRIVE;
                        idx_q   <= idx_q + 1'b1;
                        stim_q  <= idx_q + 1'b1;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign {X, Y, Z, K, M} = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = first_q;
`ifdef SWEEP_FAILMAP_EN
    logic [31:0] fail_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fail_q <= '0;
        else if (launch) fail_q <= '0;
        else if (state_q == SAMPLE && mismatch) fail_q[idx_q] <= 1'b1;
    end
    assign fail_map = fail_q;
`else
    assign fail_map = '0;
`endif
endmodule

// File: tb/tb_function_sweeper.sv
// tb_function_sweeper: scoreboard bench for function_sweeper with a minterm-list golden model.
module tb_function_sweeper;
    typedef struct {
        logic [5:0]  err;
        logic [4:0]  first;
        logic        pass;
        logic [31:0] map;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, f_in;
    logic        X, Y, Z, K, M, busy, done, pass;
    logic [5:0]  err_count;
    logic [4:0]  first_err_idx;
    logic [31:0] fail_map;
    logic [31:0] gold = '0;
    int          mode = 0, cyc = 0, start_edge = 0, done_cnt = 0, n_chk = 0, n_fail = 0, mon_e;
    bit          mon_on = 1'b0;
    exp_t        sb[$];
    exp_t        last;
    function_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in),
        .X(X), .Y(Y), .Z(Z), .K(K), .M(M),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .fail_map(fail_map)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic fin_of(input int md, input logic [4:0] i, input logic [31:0] g);
        return md == 1 ? 1'b0 : md == 2 ? 1'b1 : g[i] ^ (md == 3 && i == 5'd19);
    endfunction
    assign f_in = fin_of(mode, {X, Y, Z, K, M}, gold);
    function automatic exp_t model(input int md, input logic [31:0] g);
        exp_t r;
        r.err = '0; r.first = '0; r.pass = 1'b0; r.map = '0;
        for (int i = 0; i < 32; i++)
            if (fin_of(md, 5'(i), g) != g[i]) begin
                if (r.err == '0) r.first = 5'(i);
                r.err = r.err + 6'd1;
                r.map[i] = 1'b1;
            end
        r.pass = r.err == '0;
`ifndef SWEEP_FAILMAP_EN
        r.map = '0;
`endif
        return r;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_stim"}, {27'd0, X, Y, Z, K, M}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_pass"}, {31'd0, pass}, 0);
        check({tag, "_err"}, {26'd0, err_count}, 0);
        check({tag, "_first"}, {27'd0, first_err_idx}, 0);
        check({tag, "_map"}, fail_map, 0);
    endtask
    always @(negedge clk) if (mon_on) begin
        mon_e = cyc - start_edge;
        if (mon_e >= 0 && mon_e < 96 && mon_e % 3 == 0) begin
            check("stim", {27'd0, X, Y, Z, K, M}, 32'(mon_e / 3));
            check("busy", {31'd0, busy}, 1);
        end
        if (done) begin
            done_cnt++;
            check("done_edge", 32'(mon_e), 96);
            check("busy_at_done", {31'd0, busy}, 0);
            if (sb.size() == 0) check("sb_nonempty", 0, 1);
            else begin
                exp_t x;
                x = sb.pop_front();
                check("err_count", {26'd0, err_count}, {26'd0, x.err});
                check("first_err_idx", {27'd0, first_err_idx}, {27'd0, x.first});
                check("pass", {31'd0, pass}, {31'd0, x.pass});
                check("fail_map", fail_map, x.map);
            end
        end
    end
    task automatic run_sweep(input int md, input bit glitch);
        int base, e;
        mode = md;
        last = model(md, gold);
        sb.push_back(last);
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        mon_on = 1'b1;
        do begin
            @(negedge clk);
            e = cyc - start_edge;
            start = glitch && (e == 15 || e == 96);
        end while (e < 100);
        start = 1'b0;
        check("done_once", 32'(done_cnt - base), 1);
        check("idle_busy", {31'd0, busy}, 0);
        check("hold_err", {26'd0, err_count}, {26'd0, last.err});
        check("hold_pass", {31'd0, pass}, {31'd0, last.pass});
    endtask
    task automatic reset_mid_sweep();
        int e;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        mon_on = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            e = cyc - start_edge;
        end while (e < 31);
        check("pre_rst_idx", {27'd0, X, Y, Z, K, M}, 10);
        check("pre_rst_err", {26'd0, err_count}, 6);
        rst = 1'b1;
        mon_on = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        int mt[16];
        mt = '{0, 2, 3, 4, 6, 8, 10, 11, 15, 17, 18, 19, 21, 23, 25, 27};
        foreach (mt[i]) gold[mt[i]] = 1'b1;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);
        reset_mid_sweep();
        run_sweep(0, 1'b0);
        run_sweep(0, 1'b1);
        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
